// File: rtl/csr_ctrl_pkg.sv
// csr_ctrl_pkg: shared CSR addresses, op encodings, FSM states and trap cause
package csr_ctrl_pkg;
  localparam int XLEN = 32;
  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MCYCLEH  = 12'hB80;
  localparam logic [11:0] A_MINSTRET = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE    = 12'hC00;
  localparam logic [11:0] A_CYCLEH   = 12'hC80;
  localparam logic [11:0] A_INSTRET  = 12'hC02;
  localparam logic [11:0] A_INSTRETH = 12'hC82;
  localparam logic [2:0] OP_RW  = 3'b001;
  localparam logic [2:0] OP_RS  = 3'b010;
  localparam logic [2:0] OP_RC  = 3'b011;
  localparam logic [2:0] OP_RWI = 3'b101;
  localparam logic [2:0] OP_RSI = 3'b110;
  localparam logic [2:0] OP_RCI = 3'b111;
  localparam logic [31:0] MCAUSE_EXT_IRQ = 32'h8000_000B;
  typedef enum logic [1:0] {IDLE, TRAP, MRET} state_e;
  // immediate variants share the low two funct3 bits with the register forms
  function automatic logic [31:0] csr_apply(input logic [2:0] op, input logic [31:0] old, input logic [31:0] w);
    return op[1:0] == 2'b01 ? w : op[1:0] == 2'b10 ? (old | w) : (old & ~w);
  endfunction
endpackage

// File: rtl/csr_ctrl_if.sv
// csr_ctrl_if: EXE-stage CSR/trap signals between pipeline and CSR unit
interface csr_ctrl_if;
  import csr_ctrl_pkg::*;
  logic            csr_en_EXE;
  logic [2:0]      csr_op_EXE;
  logic [11:0]     csr_addr_EXE;
  logic [XLEN-1:0] csr_wdata_EXE;
  logic            csr_src_zero_EXE;
  logic [XLEN-1:0] pc_EXE;
  logic            stall_EXE;
  logic            retire;
  logic            mret_EXE;
  logic            ext_irq;
  logic [XLEN-1:0] csr_read_data_EXE;
  logic            csr_result_sel_EXE;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            illegal_csr;
  modport master (
    output csr_en_EXE, csr_op_EXE, csr_addr_EXE, csr_wdata_EXE, csr_src_zero_EXE,
           pc_EXE, stall_EXE, retire, mret_EXE, ext_irq,
    input  csr_read_data_EXE, csr_result_sel_EXE, redirect, redirect_pc, illegal_csr
  );
  modport slave (
    input  csr_en_EXE, csr_op_EXE, csr_addr_EXE, csr_wdata_EXE, csr_src_zero_EXE,
           pc_EXE, stall_EXE, retire, mret_EXE, ext_irq,
    output csr_read_data_EXE, csr_result_sel_EXE, redirect, redirect_pc, illegal_csr
  );
endinterface

// File: rtl/csr_counter64.sv
// csr_counter64: 64-bit wrapping counter whose halves can each be overwritten
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);
  logic [63:0] sum;
  assign sum = value + {63'b0, inc};
  // a write replaces its half and suppresses that half's increment/carry
  always_ff @(posedge clk or posedge rst)
    if (rst) value <= '0;
    else value <= {wr_hi ? wdata : sum[63:32], wr_lo ? wdata : sum[31:0]};
endmodule

// File: rtl/csr_ctrl.sv
// csr_ctrl: machine-mode CSR file with external-interrupt trap and MRET redirect
module csr_ctrl
  import csr_ctrl_pkg::*;
#(
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
  input logic clk,
  input logic rst,
  csr_ctrl_if.slave bus
);
  state_e state, state_nx;
  logic mie_b, mpie_b, meie;
  logic [31:0] mtvec, mepc, mcause, old, nv;
  logic [63:0] mcycle, minstret;
  logic idle, take, qual, known, ro, writes, wr, do_mret;
  // address decode: pre-write read value, existence and read-only flags
  always_comb begin
    old = '0;
    known = 1'b1;
    ro = 1'b0;
    case (bus.csr_addr_EXE)
      A_MSTATUS:   old = {24'b0, mpie_b, 3'b0, mie_b, 3'b0};
      A_MIE:       old = {20'b0, meie, 11'b0};
      A_MTVEC:     old = mtvec;
      A_MEPC:      old = mepc;
      A_MCAUSE:    old = mcause;
      A_MIP:       begin old = {20'b0, bus.ext_irq, 11'b0}; ro = 1'b1; end
      A_MCYCLE:    old = mcycle[31:0];
      A_MCYCLEH:   old = mcycle[63:32];
      A_MINSTRET:  old = minstret[31:0];
      A_MINSTRETH: old = minstret[63:32];
      A_CYCLE:     begin old = mcycle[31:0]; ro = 1'b1; end
      A_CYCLEH:    begin old = mcycle[63:32]; ro = 1'b1; end
      A_INSTRET:   begin old = minstret[31:0]; ro = 1'b1; end
      A_INSTRETH:  begin old = minstret[63:32]; ro = 1'b1; end
      default:     known = 1'b0;
    endcase
  end
  // access qualification, trap/mret decisions and FSM next state
  always_comb begin
    idle = state == IDLE;
    take = idle & bus.ext_irq & mie_b & meie & !bus.stall_EXE;
    qual = bus.csr_en_EXE & idle & !take & !rst;
    writes = bus.csr_op_EXE[1:0] != 2'b00 & (bus.csr_op_EXE[1:0] == 2'b01 | !bus.csr_src_zero_EXE);
    wr = qual & !bus.stall_EXE & known & !ro & writes;
    nv = csr_apply(bus.csr_op_EXE, old, bus.csr_wdata_EXE);
    do_mret = idle & bus.mret_EXE & !bus.stall_EXE & !take;
    state_nx = take ? TRAP : do_mret ? MRET : IDLE;
    bus.csr_read_data_EXE = old;
    bus.csr_result_sel_EXE = qual;
    bus.illegal_csr = qual & !bus.stall_EXE & (!known | (ro & writes));
    bus.redirect = !idle;
    bus.redirect_pc = state == TRAP ? mtvec : state == MRET ? mepc : '0;
  end
  // FSM state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // architectural CSRs; trap entry and mret override the interrupt-enable stack
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mie_b <= 1'b0;
      mpie_b <= 1'b0;
      meie <= 1'b0;
      mtvec <= MTVEC_RST;
      mepc <= '0;
      mcause <= '0;
    end else begin
      if (wr && bus.csr_addr_EXE == A_MSTATUS) begin
        mie_b <= nv[3];
        mpie_b <= nv[7];
      end
      if (wr && bus.csr_addr_EXE == A_MIE) meie <= nv[11];
      if (wr && bus.csr_addr_EXE == A_MTVEC) mtvec <= {nv[31:2], 2'b00};
      if (wr && bus.csr_addr_EXE == A_MEPC) mepc <= {nv[31:2], 2'b00};
      if (wr && bus.csr_addr_EXE == A_MCAUSE) mcause <= nv;
      if (take) begin
        mepc <= bus.pc_EXE;
        mcause <= MCAUSE_EXT_IRQ;
        mpie_b <= mie_b;
        mie_b <= 1'b0;
      end else if (do_mret) begin
        mie_b <= mpie_b;
        mpie_b <= 1'b1;
      end
    end
  csr_counter64 u_mcycle (
    .clk(clk), .rst(rst), .inc(1'b1),
    .wr_lo(wr && bus.csr_addr_EXE == A_MCYCLE),
    .wr_hi(wr && bus.csr_addr_EXE == A_MCYCLEH),
    .wdata(nv), .value(mcycle)
  );
  csr_counter64 u_minstret (
    .clk(clk), .rst(rst), .inc(bus.retire),
    .wr_lo(wr && bus.csr_addr_EXE == A_MINSTRET),
    .wr_hi(wr && bus.csr_addr_EXE == A_MINSTRETH),
    .wdata(nv), .value(minstret)
  );
endmodule

// File: doc/csr_ctrl.md
CSR_CTRL -- requirements
Module: csr_ctrl

Interface
REQ-001 Parameter: MTVEC_RST, 32'h0000_0000, mtvec reset value.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  asynchronous reset, active-high.
REQ-004 csr_en_EXE  in  1  CSR instruction valid in EXE.
REQ-005 csr_op_EXE  in  3  funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
REQ-006 csr_addr_EXE  in  12  CSR address.
REQ-007 csr_wdata_EXE  in  `data_size  rs1 value or zero-extended zimm, selected upstream.
REQ-008 csr_src_zero_EXE  in  1  rs1 index/zimm equals 0.
REQ-009 pc_EXE  in  `data_size  PC of the EXE instruction.
REQ-010 stall_EXE  in  1  EXE held; no state update.
REQ-011 retire  in  1  one instruction retired this cycle.
REQ-012 mret_EXE  in  1  MRET valid in EXE.
REQ-013 ext_irq  in  1  level external interrupt.
REQ-014 csr_read_data_EXE  out  `data_size  old CSR value, combinational.
REQ-015 csr_result_sel_EXE  out  1  selects CSR data over ALU result.
REQ-016 redirect  out  1  PC redirect and pipeline flush.
REQ-017 redirect_pc  out  `data_size  redirect target.
REQ-018 illegal_csr  out  1  unknown address, or write to read-only CSR.

Function
REQ-019 Map: mstatus 0x300 (MIE bit3, MPIE bit7, other bits read 0), mie 0x304 (MEIE bit11), mtvec 0x305, mepc 0x341, mcause 0x342, mip 0x344 (RO, MEIP bit11 = ext_irq), mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82, cycle/cycleh/instret/instreth 0xC00/0xC80/0xC02/0xC82 (RO aliases).
REQ-020 csr_result_sel_EXE = csr_en_EXE when state IDLE and no interrupt taken this cycle; else 0.
REQ-021 csr_read_data_EXE returns the pre-write value; unknown address reads 0.
REQ-022 New value: RW = wdata; RS = old | wdata; RC = old & ~wdata.
REQ-023 RS/RC with csr_src_zero_EXE=1 perform no write and raise no read-only fault.
REQ-024 Write commits at clock edge when csr_en_EXE & state IDLE & !stall_EXE & no interrupt taken.
REQ-025 illegal_csr is combinational under the same qualifiers; illegal accesses never write.
REQ-026 mepc bits[1:0] and mtvec bits[1:0] are forced to 0 on write.
REQ-027 mcycle (64-bit) increments every cycle, wrapping 2^64-1 to 0; a CSR write to either half replaces that half's value that cycle (write wins over increment).
REQ-028 minstret (64-bit) increments on retire, same wrap and write-wins rules.
REQ-029 FSM states: IDLE, TRAP, MRET.
REQ-030 IDLE -> TRAP when ext_irq & MIE & MEIE & !stall_EXE; the EXE instruction (including a CSR access) is abandoned.
REQ-031 IDLE -> MRET when mret_EXE & !stall_EXE and no interrupt taken; interrupt has priority.
REQ-032 IDLE -> TRAP edge: mepc <= pc_EXE, mcause <= 32'h8000_000B, MPIE <= MIE, MIE <= 0.
REQ-033 IDLE -> MRET edge: MIE <= MPIE, MPIE <= 1.
REQ-034 TRAP: redirect=1, redirect_pc = mtvec; next IDLE.
REQ-035 MRET: redirect=1, redirect_pc = mepc; next IDLE.
REQ-036 Outside TRAP/MRET: redirect=0, redirect_pc=0; TRAP and MRET ignore stall_EXE and all EXE inputs.

Reset
REQ-037 rst asserted: state IDLE; mstatus, mie, mepc, mcause, mcycle, minstret = 0; mtvec = MTVEC_RST; redirect, csr_result_sel_EXE, illegal_csr = 0.
REQ-038 Reset during TRAP/MRET aborts the redirect; no partial CSR update survives.

Structure
REQ-039 Shared package: CSR address constants, csr_op encodings, FSM state enum, mcause value.
REQ-040 One sub-module: csr_counter64 (64-bit counter with increment enable and per-half write), instantiated twice.

Verification
REQ-041 CSRRW 0x305 wdata 32'h0000_1003 -> read 0 (MTVEC_RST=0); next read of mtvec = 32'h0000_1000.
REQ-042 CSRRS 0x300 wdata 8 -> MIE=1; CSRRC 0x300 with csr_src_zero_EXE=1 -> no change, illegal_csr=0.
REQ-043 MIE=1, MEIE=1, ext_irq=1, pc_EXE 32'h80 with CSR access -> no write; mepc=32'h80, mcause=32'h8000_000B, MIE=0, MPIE=1; redirect to mtvec for one cycle.
REQ-044 mret_EXE after REQ-043 -> MIE=1, MPIE=1, redirect_pc=32'h80.
REQ-045 Write mcycle=32'hFFFF_FFFF with mcycleh=0 -> two cycles later mcycleh=1, mcycle=1; CSRRW 0xC00 -> illegal_csr=1, no write.
REQ-046 stall_EXE=1 with CSRRW 0x341 -> mepc unchanged; rst mid-TRAP -> redirect=0 and state IDLE immediately.
